// File: rtl/bus_dma_engine.sv
// bus_dma_engine
//   Memory-to-memory DMA master in front of the bus arbitrator. Copies
//   word_count 32-bit words from src_addr to dst_addr as alternating
//   read/write cycles on the shared tri-state bus. It drives the bus only
//   while it is granted. The CPU may pre-empt it in any cycle.
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   start                     transfer request, sampled only in IDLE
//   src_addr, dst_addr        byte addresses, latched on an accepted start
//   word_count                number of words, latched on an accepted start
//   busy, done, error         CPU-side status (done/error are 1-cycle pulses)
//   dma_req, dma_grant        arbitrator handshake
//   addr_bus, data_bus,
//   wr_bus, rd_bus,
//   data_mask_bus             shared tri-state bus; 'z unless granted in READ/WRITE
//   fc_bus                    function complete from the addressed slave
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start, bus released, no request
// S_READ  | requesting bus; when granted, reading word at src
// S_WRITE | requesting bus; when granted, writing buffered word to dst
// S_DONE  | one-cycle done pulse, then back to IDLE
// S_ERR   | one-cycle error pulse after an access timeout, then IDLE

module bus_dma_engine #(
   parameter int COUNT_W = 16,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [31:0]        src_addr,
   input  logic [31:0]        dst_addr,
   input  logic [COUNT_W-1:0] word_count,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic               dma_req,
   input  logic               dma_grant,
   inout  wire  [31:0]        addr_bus,
   inout  wire  [31:0]        data_bus,
   inout  wire                wr_bus,
   inout  wire                rd_bus,
   inout  wire  [3:0]         data_mask_bus,
   input  logic               fc_bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT);

   state_t             state_q, state_d;
   logic [31:0]        src_q, dst_q, buf_q;
   logic [COUNT_W-1:0] rem_q;
   logic [7:0]         tmo_q;

   logic in_access, acc_ok, tmo_hit, drive;
   logic [31:0] cur_addr;

   assign in_access = (state_q == S_READ) || (state_q == S_WRITE);
   assign acc_ok    = dma_grant && fc_bus;
   // Timer is a down-counter: terminal count on the last granted, incomplete
   // cycle. fc in the same cycle takes priority because acc_ok is tested first.
   assign tmo_hit   = dma_grant && !fc_bus && (tmo_q == 8'd1);
   assign drive     = dma_grant && in_access;
   assign cur_addr  = (state_q == S_WRITE) ? dst_q : src_q;

   always_comb begin
      state_d = state_q;
      busy    = (state_q != S_IDLE);
      done    = (state_q == S_DONE);
      error   = (state_q == S_ERR);
      dma_req = in_access;
      case (state_q)
         S_IDLE: begin
            if (start)
               state_d = (word_count == '0) ? S_DONE : S_READ;
         end
         S_READ: begin
            if (acc_ok)
               state_d = S_WRITE;
            else if (tmo_hit)
               state_d = S_ERR;
         end
         S_WRITE: begin
            if (acc_ok)
               state_d = (rem_q == COUNT_W'(1)) ? S_DONE : S_READ;
            else if (tmo_hit)
               state_d = S_ERR;
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         src_q <= '0;
         dst_q <= '0;
         rem_q <= '0;
         buf_q <= '0;
      end else begin
         if (state_q == S_IDLE && start) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            rem_q <= word_count;
         end
         if (state_q == S_READ && acc_ok)
            buf_q <= data_bus;
         if (state_q == S_WRITE && acc_ok) begin
            src_q <= src_q + 32'd4;
            dst_q <= dst_q + 32'd4;
            rem_q <= rem_q - COUNT_W'(1);
         end
      end
   end

   // Reload whenever the access is not actively stalling under grant, so
   // CPU pre-emption never contributes toward a timeout.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         tmo_q <= TMO_LOAD;
      else if (!in_access || !dma_grant || fc_bus || (state_d != state_q))
         tmo_q <= TMO_LOAD;
      else
         tmo_q <= tmo_q - 8'd1;
   end

   // Low two address bits are never presented on the bus.
   assign addr_bus      = drive ? (cur_addr & 32'hFFFF_FFFC) : 32'bz;
   assign data_bus      = (drive && state_q == S_WRITE) ? buf_q : 32'bz;
   assign wr_bus        = drive ? (state_q == S_WRITE) : 1'bz;
   assign rd_bus        = drive ? (state_q == S_READ) : 1'bz;
   assign data_mask_bus = drive ? 4'hF : 4'bz;

endmodule

// File: tb/tb_bus_dma_engine.sv
module tb_bus_dma_engine;

   logic        clk, rst, start, dma_grant, fc_bus;
   logic [31:0] src_addr, dst_addr;
   logic [15:0] word_count;
   logic        busy, done, error, dma_req;
   wire  [31:0] addr_bus, data_bus;
   wire         wr_bus, rd_bus;
   wire  [3:0]  data_mask_bus;
   logic        sdrv;
   logic [31:0] sdat;

   int n_chk = 0;
   int n_fail = 0;

   // Distinct released levels make a floating bus observable:
   // addr/data float high, mask/rd float low, wr floats high.
   pullup   (addr_bus);
   pullup   (data_bus);
   pullup   (wr_bus);
   pulldown (rd_bus);
   pulldown (data_mask_bus);

   assign data_bus = sdrv ? sdat : 32'bz;

   bus_dma_engine #(.COUNT_W(16), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
      .busy(busy), .done(done), .error(error),
      .dma_req(dma_req), .dma_grant(dma_grant),
      .addr_bus(addr_bus), .data_bus(data_bus),
      .wr_bus(wr_bus), .rd_bus(rd_bus), .data_mask_bus(data_mask_bus),
      .fc_bus(fc_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic [31:0] src, dst;
      logic [15:0] cnt;
      logic        gnt, fc, sdrv;
      logic [31:0] sdat;
      logic        busy, done, err, req;
      logic [31:0] addr;
      logic        rd, wr;
      logic [3:0]  mask;
      logic [31:0] data;
   } vec_t;

   function automatic vec_t v_base();
      vec_t v;
      v.st = 0; v.src = 0; v.dst = 0; v.cnt = 0;
      v.gnt = 0; v.fc = 0; v.sdrv = 0; v.sdat = 0;
      v.busy = 0; v.done = 0; v.err = 0; v.req = 0;
      v.addr = 32'hFFFF_FFFF; v.rd = 0; v.wr = 1; v.mask = 4'h0;
      v.data = 32'hFFFF_FFFF;
      return v;
   endfunction

   function automatic vec_t v_idle(logic st, logic [31:0] s, logic [31:0] d,
                                   logic [15:0] c, logic g);
      vec_t v = v_base();
      v.st = st; v.src = s; v.dst = d; v.cnt = c; v.gnt = g;
      return v;
   endfunction

   function automatic vec_t v_rd(logic g, logic f, logic [31:0] sd, logic [31:0] a);
      vec_t v = v_base();
      v.gnt = g; v.fc = f; v.busy = 1; v.req = 1;
      if (g) begin
         v.addr = a; v.rd = 1; v.wr = 0; v.mask = 4'hF;
         v.sdrv = f; v.sdat = sd;
         v.data = f ? sd : 32'hFFFF_FFFF;
      end
      return v;
   endfunction

   function automatic vec_t v_wr(logic g, logic f, logic [31:0] a, logic [31:0] d);
      vec_t v = v_base();
      v.gnt = g; v.fc = f; v.busy = 1; v.req = 1;
      if (g) begin
         v.addr = a; v.rd = 0; v.wr = 1; v.mask = 4'hF; v.data = d;
      end
      return v;
   endfunction

   function automatic vec_t v_done(logic g);
      vec_t v = v_base();
      v.gnt = g; v.busy = 1; v.done = 1;
      return v;
   endfunction

   function automatic vec_t v_err(logic g);
      vec_t v = v_base();
      v.gnt = g; v.busy = 1; v.err = 1;
      return v;
   endfunction

   task automatic check(input vec_t v, input string nm);
      logic [73:0] obs, exp;
      obs = {busy, done, error, dma_req, rd_bus, wr_bus, data_mask_bus, addr_bus, data_bus};
      exp = {v.busy, v.done, v.err, v.req, v.rd, v.wr, v.mask, v.addr, v.data};
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got bdeq_rw_m_addr_data=%h required %h", nm, obs, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string nm);
      @(negedge clk);
      start = v.st; src_addr = v.src; dst_addr = v.dst; word_count = v.cnt;
      dma_grant = v.gnt; fc_bus = v.fc; sdrv = v.sdrv; sdat = v.sdat;
      #1;
      check(v, nm);
   endtask

   vec_t tbl[$];
   vec_t v;

   initial begin
      rst = 0; start = 0; src_addr = 0; dst_addr = 0; word_count = 0;
      dma_grant = 0; fc_bus = 0; sdrv = 0; sdat = 0;

      // reset: start and grant present but held off by reset
      apply(v_idle(1, 32'h100, 32'h200, 16'd5, 1), "reset");
      start = 0;
      rst = 1;

      // basic 2-word copy, fc one cycle after each access begins
      tbl.push_back(v_idle(1, 32'h100, 32'h200, 16'd2, 1));
      tbl.push_back(v_rd(1, 0, 0, 32'h100));
      tbl.push_back(v_rd(1, 1, 32'hA1A1_0001, 32'h100));
      tbl.push_back(v_wr(1, 0, 32'h200, 32'hA1A1_0001));
      tbl.push_back(v_wr(1, 1, 32'h200, 32'hA1A1_0001));
      tbl.push_back(v_rd(1, 0, 0, 32'h104));
      tbl.push_back(v_rd(1, 1, 32'hA2A2_0002, 32'h104));
      tbl.push_back(v_wr(1, 0, 32'h204, 32'hA2A2_0002));
      tbl.push_back(v_wr(1, 1, 32'h204, 32'hA2A2_0002));
      tbl.push_back(v_done(1));
      tbl.push_back(v_idle(0, 0, 0, 0, 1));
      // zero-length transfer
      tbl.push_back(v_idle(1, 32'h123, 32'h456, 16'd0, 1));
      tbl.push_back(v_done(1));
      tbl.push_back(v_idle(0, 0, 0, 0, 1));
      // source wraps past 2^32, unaligned destination
      tbl.push_back(v_idle(1, 32'hFFFF_FFFC, 32'h303, 16'd2, 1));
      tbl.push_back(v_rd(1, 1, 32'hB1B1_0001, 32'hFFFF_FFFC));
      v = v_wr(1, 1, 32'h300, 32'hB1B1_0001);
      v.st = 1; v.src = 32'h999; v.cnt = 16'd7;   // start ignored mid-transfer
      tbl.push_back(v);
      tbl.push_back(v_rd(1, 1, 32'hB2B2_0002, 32'h0000_0000));
      tbl.push_back(v_wr(1, 1, 32'h304, 32'hB2B2_0002));
      tbl.push_back(v_done(1));
      tbl.push_back(v_idle(0, 0, 0, 0, 1));
      // unaligned source
      tbl.push_back(v_idle(1, 32'h103, 32'h400, 16'd1, 1));
      tbl.push_back(v_rd(1, 1, 32'hC1C1_0001, 32'h100));
      tbl.push_back(v_wr(1, 1, 32'h400, 32'hC1C1_0001));
      tbl.push_back(v_done(1));
      tbl.push_back(v_idle(0, 0, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], $sformatf("tbl[%0d]", i));

      // CPU pre-empts during WRITE; fc without grant must be ignored
      apply(v_idle(1, 32'h500, 32'h600, 16'd1, 1), "pre start");
      apply(v_rd(1, 1, 32'hD1D1_0001, 32'h500), "pre read");
      apply(v_wr(1, 0, 32'h600, 32'hD1D1_0001), "pre write stall");
      apply(v_wr(0, 0, 32'h600, 32'hD1D1_0001), "pre drop 1");
      apply(v_wr(0, 1, 32'h600, 32'hD1D1_0001), "pre drop 2 fc");
      apply(v_wr(0, 0, 32'h600, 32'hD1D1_0001), "pre drop 3");
      apply(v_wr(1, 0, 32'h600, 32'hD1D1_0001), "pre regrant 1");
      apply(v_wr(1, 0, 32'h600, 32'hD1D1_0001), "pre regrant 2");
      apply(v_wr(1, 0, 32'h600, 32'hD1D1_0001), "pre regrant 3");
      apply(v_wr(1, 1, 32'h600, 32'hD1D1_0001), "pre write fc");
      apply(v_done(1), "pre done");
      apply(v_idle(0, 0, 0, 0, 1), "pre idle");

      // slave never answers: timeout after 4 granted cycles
      apply(v_idle(1, 32'h700, 32'h780, 16'd1, 1), "tmo start");
      for (int i = 0; i < 4; i++)
         apply(v_rd(1, 0, 0, 32'h700), $sformatf("tmo stall %0d", i));
      apply(v_err(1), "tmo error");
      apply(v_idle(0, 0, 0, 0, 1), "tmo idle");

      // fc on the terminal-count cycle wins over timeout
      apply(v_idle(1, 32'h710, 32'h790, 16'd1, 1), "race start");
      for (int i = 0; i < 3; i++)
         apply(v_rd(1, 0, 0, 32'h710), $sformatf("race stall %0d", i));
      apply(v_rd(1, 1, 32'hE1E1_0001, 32'h710), "race fc");
      apply(v_wr(1, 1, 32'h790, 32'hE1E1_0001), "race write");
      apply(v_done(1), "race done");
      apply(v_idle(0, 0, 0, 0, 1), "race idle");

      // asynchronous reset mid-READ
      apply(v_idle(1, 32'h800, 32'h880, 16'd2, 1), "rst start");
      apply(v_rd(1, 0, 0, 32'h800), "rst read");
      #2;
      rst = 0;
      #1;
      check(v_idle(0, 0, 0, 0, 1), "rst async");
      apply(v_idle(0, 0, 0, 0, 1), "rst held");
      rst = 1;
      apply(v_idle(1, 32'h900, 32'h980, 16'd1, 1), "rst restart");
      v = v_rd(1, 1, 32'hF1F1_0001, 32'h900);
      v.st = 1; v.src = 32'hA00; v.cnt = 16'd3;
      apply(v, "busy start ignored rd");
      apply(v_wr(1, 1, 32'h980, 32'hF1F1_0001), "rst write");
      v = v_done(1);
      v.st = 1; v.src = 32'hA00; v.cnt = 16'd3;
      apply(v, "busy start ignored done");
      apply(v_idle(1, 32'hB00, 32'hB80, 16'd1, 1), "idle start accepted");
      apply(v_rd(1, 1, 32'hF2F2_0002, 32'hB00), "accepted read");
      apply(v_wr(1, 1, 32'hB80, 32'hF2F2_0002), "accepted write");
      apply(v_done(1), "accepted done");
      apply(v_idle(0, 0, 0, 0, 0), "final idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
